axonerve_axi_mem_responder: RTL and testbench

AXONERVE_AXI_MEM_RESPONDER -- requirements
Module: axonerve_axi_mem_responder

---
 rtl/axonerve_axi_mem_pkg.sv | 24 ++
 rtl/axonerve_axi_mem_lfsr.sv | 28 ++
 rtl/axonerve_axi_mem_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_axonerve_axi_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axonerve_axi_mem_pkg.sv
// Shared types and constants for the AXI memory responder: FSM state encodings,
// beat-offset helper and the stall-LFSR seed.
package axonerve_axi_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Byte-offset bits for the default 512-bit data bus.
  localparam int AXI_MEM_OFS_DEFAULT = 6;
  localparam logic [15:0] AXI_MEM_STALL_SEED = 16'hACE1;

  function automatic int calc_ofs(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axonerve_axi_mem_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) producing a pseudo-random stall
// strobe for the responder when AXONERVE_AXI_MEM_STALL_EN is defined.
module axonerve_axi_mem_lfsr
  import axonerve_axi_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic stall
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= AXI_MEM_STALL_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/axonerve_axi_mem_responder.sv
// AXI4 burst memory responder with independent write and read FSMs over a
// byte-strobed word array; optional random stalls via AXONERVE_AXI_MEM_STALL_EN.
module axonerve_axi_mem_responder
  import axonerve_axi_mem_pkg::*;
#(
  parameter int C_M00_AXI_ADDR_WIDTH = 64,
  parameter int C_M00_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH_LOG2     = 10
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  input  logic                              m00_axi_awvalid,
  output logic                              m00_axi_awready,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  input  logic [7:0]                        m00_axi_awlen,
  input  logic                              m00_axi_wvalid,
  output logic                              m00_axi_wready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  input  logic                              m00_axi_wlast,
  output logic                              m00_axi_bvalid,
  input  logic                              m00_axi_bready,
  input  logic                              m00_axi_arvalid,
  output logic                              m00_axi_arready,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  input  logic [7:0]                        m00_axi_arlen,
  output logic                              m00_axi_rvalid,
  input  logic                              m00_axi_rready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  output logic                              m00_axi_rlast,
  output logic                              proto_err
);

  localparam int OFS   = calc_ofs(C_M00_AXI_DATA_WIDTH);
  localparam int DEPTH = 1 << C_MEM_DEPTH_LOG2;
  localparam int SW    = C_M00_AXI_DATA_WIDTH / 8;
  localparam int DW    = C_M00_AXI_DATA_WIDTH;

  typedef logic [C_MEM_DEPTH_LOG2-1:0] idx_t;

  // Handshake rule: a transfer happens on a rising edge where valid && ready;
  // a raised valid is held with stable payload until that transfer.
  logic stall;
`ifdef AXONERVE_AXI_MEM_STALL_EN
  axonerve_axi_mem_lfsr u_lfsr (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .stall (stall)
  );
`else
  assign stall = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{m00_axi_awaddr, m00_axi_araddr};

  logic [DW-1:0] mem_q [DEPTH];

  w_state_e   w_state_q, w_state_d;
  idx_t       w_idx_q, w_idx_d;
  logic [7:0] w_len_q, w_len_d;
  logic [7:0] w_beat_q, w_beat_d;
  logic       awready_q, awready_d;
  logic       wready_q, wready_d;
  logic       bvalid_q, bvalid_d;
  logic       proto_err_q, proto_err_d;
  logic       mem_we;

  r_state_e   r_state_q, r_state_d;
  idx_t       r_idx_q, r_idx_d;
  logic [7:0] r_len_q, r_len_d;
  logic [7:0] r_beat_q, r_beat_d;
  logic       arready_q, arready_d;
  logic       rvalid_q, rvalid_d;
  logic       rlast_q, rlast_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic       launch;

  assign m00_axi_awready = awready_q && !stall;
  assign m00_axi_wready  = wready_q && !stall;
  assign m00_axi_arready = arready_q && !stall;
  assign m00_axi_bvalid  = bvalid_q;
  assign m00_axi_rvalid  = rvalid_q;
  assign m00_axi_rlast   = rlast_q;
  assign m00_axi_rdata   = rdata_q;
  assign proto_err       = proto_err_q;

  always_comb begin
    w_state_d   = w_state_q;
    w_idx_d     = w_idx_q;
    w_len_d     = w_len_q;
    w_beat_d    = w_beat_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (m00_axi_awvalid && m00_axi_awready) begin
          w_state_d = W_DATA;
          w_idx_d   = m00_axi_awaddr[OFS +: C_MEM_DEPTH_LOG2];
          w_len_d   = m00_axi_awlen;
          w_beat_d  = 8'd0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
        end
      end
      W_DATA: begin
        if (m00_axi_wvalid && m00_axi_wready) begin
          mem_we   = 1'b1;
          w_idx_d  = w_idx_q + idx_t'(1);
          w_beat_d = w_beat_q + 8'd1;
          // Burst length follows awlen; a misplaced wlast is only flagged.
          if (m00_axi_wlast != (w_beat_q == w_len_q)) proto_err_d = 1'b1;
          if (w_beat_q == w_len_q) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && m00_axi_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      w_state_q   <= W_IDLE;
      w_idx_q     <= '0;
      w_len_q     <= '0;
      w_beat_q    <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      w_idx_q     <= w_idx_d;
      w_len_q     <= w_len_d;
      w_beat_q    <= w_beat_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Contents survive reset; a same-cycle read samples the old word.
  always_ff @(posedge ap_clk) begin
    if (mem_we) begin
      for (int b = 0; b < SW; b++) begin
        if (m00_axi_wstrb[b]) mem_q[w_idx_q][b*8 +: 8] <= m00_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    launch    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (m00_axi_arvalid && m00_axi_arready) begin
          r_state_d = R_DATA;
          r_idx_d   = m00_axi_araddr[OFS +: C_MEM_DEPTH_LOG2];
          r_len_d   = m00_axi_arlen;
          r_beat_d  = 8'd0;
          arready_d = 1'b0;
          launch    = 1'b1;
        end
      end
      R_DATA: begin
        if (rvalid_q && m00_axi_rready) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            r_idx_d  = r_idx_q + idx_t'(1);
            r_beat_d = r_beat_q + 8'd1;
            launch   = 1'b1;
          end
        end else if (!rvalid_q) begin
          launch = 1'b1;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
    // A new beat is only launched, never withdrawn, so stall cannot drop a held rvalid.
    if (launch) begin
      rvalid_d = !stall;
      rdata_d  = mem_q[r_idx_d];
      rlast_d  = (r_beat_d == r_len_d);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axonerve_axi_mem_responder.sv
// Directed self-checking bench for axonerve_axi_mem_responder (default build).
module tb_axonerve_axi_mem_responder;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          bvalid;
  logic          bready = 1'b0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic          proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] beat_data [16];
  logic [SW-1:0] beat_strb [16];
  logic [DW-1:0] rd_data [16];
  logic          rd_last [16];

  axonerve_axi_mem_responder #(
    .C_M00_AXI_ADDR_WIDTH (AW),
    .C_M00_AXI_DATA_WIDTH (DW),
    .C_MEM_DEPTH_LOG2     (10)
  ) dut (
    .ap_clk          (clk),
    .ap_rst_n        (rst_n),
    .m00_axi_awvalid (awvalid),
    .m00_axi_awready (awready),
    .m00_axi_awaddr  (awaddr),
    .m00_axi_awlen   (awlen),
    .m00_axi_wvalid  (wvalid),
    .m00_axi_wready  (wready),
    .m00_axi_wdata   (wdata),
    .m00_axi_wstrb   (wstrb),
    .m00_axi_wlast   (wlast),
    .m00_axi_bvalid  (bvalid),
    .m00_axi_bready  (bready),
    .m00_axi_arvalid (arvalid),
    .m00_axi_arready (arready),
    .m00_axi_araddr  (araddr),
    .m00_axi_arlen   (arlen),
    .m00_axi_rvalid  (rvalid),
    .m00_axi_rready  (rready),
    .m00_axi_rdata   (rdata),
    .m00_axi_rlast   (rlast),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic drive_write(input logic [AW-1:0] addr, input int len, input int wlast_beat,
                             output bit bv_ok);
    int n;
    bv_ok = 1'b1;
    awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin n_fail++; $display("FAIL aw_timeout awready=%0b want 1", awready); end
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wvalid = 1'b1; wdata = beat_data[b]; wstrb = beat_strb[b]; wlast = (b == wlast_beat);
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) begin n_fail++; $display("FAIL w_timeout beat %0d wready=%0b want 1", b, wready); end
      if (bvalid) bv_ok = 1'b0;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (!bvalid) bv_ok = 1'b0;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    if (bvalid) bv_ok = 1'b0;
  endtask

  task automatic drive_read(input logic [AW-1:0] addr, input int len, input int hold_beat,
                            input int hold_cycles, output bit hold_ok, output bit end_ok);
    int n;
    hold_ok = 1'b1;
    araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin n_fail++; $display("FAIL ar_timeout arready=%0b want 1", arready); end
    @(negedge clk);
    arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      if (!rvalid) begin n_fail++; $display("FAIL r_timeout beat %0d rvalid=%0b want 1", b, rvalid); end
      rd_data[b] = rdata; rd_last[b] = rlast;
      if (b == hold_beat) begin
        for (int k = 0; k < hold_cycles; k++) begin
          @(negedge clk);
          if (rvalid !== 1'b1 || rdata !== rd_data[b] || rlast !== rd_last[b]) hold_ok = 1'b0;
        end
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
    end_ok = (rvalid === 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (awready !== 1'b0) begin n_fail++; $display("FAIL rst_awready got %0b want 0", awready); end
    n_checks++; if (wready !== 1'b0) begin n_fail++; $display("FAIL rst_wready got %0b want 0", wready); end
    n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid got %0b want 0", bvalid); end
    n_checks++; if (arready !== 1'b0) begin n_fail++; $display("FAIL rst_arready got %0b want 0", arready); end
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %0b want 0", rvalid); end
    n_checks++; if (rlast !== 1'b0) begin n_fail++; $display("FAIL rst_rlast got %0b want 0", rlast); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_proto_err got %0b want 0", proto_err); end
    n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL rst_rdata got %0h want 0", rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (awready !== 1'b1) begin n_fail++; $display("FAIL rel_awready got %0b want 1", awready); end
    n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL rel_arready got %0b want 1", arready); end
  endtask

  task automatic test_burst();
    bit bv_ok, hold_ok, end_ok;
    logic [DW-1:0] exp;
    for (int b = 0; b < 4; b++) begin beat_data[b] = DW'(b + 1); beat_strb[b] = '1; end
    drive_write(64'h1000, 3, 3, bv_ok);
    n_checks++; if (bv_ok !== 1'b1) begin n_fail++; $display("FAIL burst_bvalid_timing got %0b want 1", bv_ok); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL burst_proto_err got %0b want 0", proto_err); end
    drive_read(64'h1000, 3, -1, 0, hold_ok, end_ok);
    for (int b = 0; b < 4; b++) begin
      exp = DW'(b + 1);
      n_checks++; if (rd_data[b] !== exp) begin n_fail++; $display("FAIL burst_rdata beat %0d got %0h want %0h", b, rd_data[b], exp); end
      n_checks++; if (rd_last[b] !== (b == 3)) begin n_fail++; $display("FAIL burst_rlast beat %0d got %0b want %0b", b, rd_last[b], (b == 3)); end
    end
    n_checks++; if (end_ok !== 1'b1) begin n_fail++; $display("FAIL burst_rvalid_end got %0b want 1", end_ok); end
  endtask

  task automatic test_strobe();
    bit bv_ok, hold_ok, end_ok;
    logic [DW-1:0] exp;
    beat_data[0] = '1; beat_strb[0] = '1;
    drive_write(64'h2000, 0, 0, bv_ok);
    beat_data[0] = {SW{8'h5A}}; beat_strb[0] = SW'(1);
    drive_write(64'h2000, 0, 0, bv_ok);
    n_checks++; if (bv_ok !== 1'b1) begin n_fail++; $display("FAIL strobe_bvalid_timing got %0b want 1", bv_ok); end
    exp = '1; exp[7:0] = 8'h5A;
    drive_read(64'h2000, 0, -1, 0, hold_ok, end_ok);
    n_checks++; if (rd_data[0] !== exp) begin n_fail++; $display("FAIL strobe_rdata got %0h want %0h", rd_data[0], exp); end
    n_checks++; if (rd_last[0] !== 1'b1) begin n_fail++; $display("FAIL strobe_rlast got %0b want 1", rd_last[0]); end
  endtask

  task automatic test_wrap();
    bit bv_ok, hold_ok, end_ok;
    logic [DW-1:0] exp;
    for (int b = 0; b < 4; b++) begin beat_data[b] = DW'(8'hA0 + b); beat_strb[b] = '1; end
    drive_write(64'hFFC0, 3, 3, bv_ok);
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL wrap_proto_err got %0b want 0", proto_err); end
    drive_read(64'hFFC0, 3, -1, 0, hold_ok, end_ok);
    for (int b = 0; b < 4; b++) begin
      exp = DW'(8'hA0 + b);
      n_checks++; if (rd_data[b] !== exp) begin n_fail++; $display("FAIL wrap_rdata beat %0d got %0h want %0h", b, rd_data[b], exp); end
    end
    drive_read(64'hF000_0000_0000_003F, 0, -1, 0, hold_ok, end_ok);
    exp = DW'(8'hA1);
    n_checks++; if (rd_data[0] !== exp) begin n_fail++; $display("FAIL wrap_index0 got %0h want %0h", rd_data[0], exp); end
    drive_read(64'h0080, 0, -1, 0, hold_ok, end_ok);
    exp = DW'(8'hA3);
    n_checks++; if (rd_data[0] !== exp) begin n_fail++; $display("FAIL wrap_index2 got %0h want %0h", rd_data[0], exp); end
  endtask

  task automatic test_rready_hold();
    bit hold_ok, end_ok;
    logic [DW-1:0] exp;
    drive_read(64'h1000, 3, 1, 5, hold_ok, end_ok);
    n_checks++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL hold_stable got %0b want 1", hold_ok); end
    for (int b = 0; b < 4; b++) begin
      exp = DW'(b + 1);
      n_checks++; if (rd_data[b] !== exp) begin n_fail++; $display("FAIL hold_rdata beat %0d got %0h want %0h", b, rd_data[b], exp); end
    end
    n_checks++; if (rd_last[3] !== 1'b1) begin n_fail++; $display("FAIL hold_rlast got %0b want 1", rd_last[3]); end
    n_checks++; if (end_ok !== 1'b1) begin n_fail++; $display("FAIL hold_rvalid_end got %0b want 1", end_ok); end
  endtask

  task automatic test_collision();
    bit bv_ok, hold_ok, end_ok;
    logic [DW-1:0] v0, v1;
    v0 = {SW{8'h3C}}; v1 = {SW{8'hC3}};
    beat_data[0] = v0; beat_strb[0] = '1;
    drive_write(64'h4B00, 0, 0, bv_ok);
    @(negedge clk);
    awaddr = 64'h4B00; awlen = 8'd0; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = v1; wstrb = '1; wlast = 1'b1;
    araddr = 64'h4B00; arlen = 8'd0; arvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL coll_rvalid got %0b want 1", rvalid); end
    n_checks++; if (rdata !== v0) begin n_fail++; $display("FAIL coll_old_data got %0h want %0h", rdata, v0); end
    n_checks++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL coll_bvalid got %0b want 1", bvalid); end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    drive_read(64'h4B00, 0, -1, 0, hold_ok, end_ok);
    n_checks++; if (rd_data[0] !== v1) begin n_fail++; $display("FAIL coll_commit got %0h want %0h", rd_data[0], v1); end
  endtask

  task automatic test_proto_err();
    bit bv_ok, hold_ok, end_ok;
    logic [DW-1:0] exp;
    for (int b = 0; b < 4; b++) begin beat_data[b] = DW'(8'h11 + b); beat_strb[b] = '1; end
    drive_write(64'h7D00, 3, 1, bv_ok);
    n_checks++; if (bv_ok !== 1'b1) begin n_fail++; $display("FAIL perr_bvalid_timing got %0b want 1", bv_ok); end
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_set got %0b want 1", proto_err); end
    drive_write(64'h8000, 0, 0, bv_ok);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky got %0b want 1", proto_err); end
    drive_read(64'h7D00, 3, -1, 0, hold_ok, end_ok);
    exp = DW'(8'h14);
    n_checks++; if (rd_data[3] !== exp) begin n_fail++; $display("FAIL perr_beat4 got %0h want %0h", rd_data[3], exp); end
  endtask

  task automatic test_reset_mid_read();
    bit hold_ok, end_ok;
    int n;
    logic [DW-1:0] exp;
    araddr = 64'h1000; arlen = 8'd3; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rvalid got %0b want 0", rvalid); end
    n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL mid_rst_rdata got %0h want 0", rdata); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_proto_err got %0b want 0", proto_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_arready got %0b want 1", arready); end
    n_checks++; if (awready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_awready got %0b want 1", awready); end
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rel_rvalid got %0b want 0", rvalid); end
    drive_read(64'h1000, 0, -1, 0, hold_ok, end_ok);
    exp = DW'(1);
    n_checks++; if (rd_data[0] !== exp) begin n_fail++; $display("FAIL mid_mem_kept got %0h want %0h", rd_data[0], exp); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_strobe();
    test_wrap();
    test_rready_hold();
    test_collision();
    test_proto_err();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
